// File: rtl/text_line_scheduler_if.sv
// Memory-side bus of the text line scheduler: character RAM and font ROM
// read ports, both with one cycle of read latency.
interface text_line_scheduler_if #(
  parameter int IDX_W = 4
) ();
  logic [IDX_W-1:0] char_addr;
  logic [7:0]       char_data;
  logic [10:0]      font_addr;
  logic [7:0]       font_data;

  modport master (
    output char_addr,
    output font_addr,
    input  char_data,
    input  font_data
  );

  modport slave (
    input  char_addr,
    input  font_addr,
    output char_data,
    output font_data
  );
endinterface

// File: rtl/text_line_scheduler.sv
// Prefetches one scanline of 8x16 glyph rows into a ping-pong line buffer
// while the other bank drives pixel_on for the current scanline.
module text_line_scheduler #(
  parameter int MAX_CHARS = 16,
  parameter int IDX_W     = 4
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic [9:0]           DrawX,
  input  logic [9:0]           DrawY,
  input  logic                 new_line,
  input  logic [9:0]           line_y,
  input  logic [10:0]          text_x,
  input  logic [10:0]          text_y,
  input  logic [IDX_W:0]       text_len,
  text_line_scheduler_if.master mem,
  output logic                 pixel_on,
  output logic                 busy,
  output logic                 overrun
);

  typedef enum logic [1:0] {
    IDLE,
    CHAR_RD,
    FONT_RD,
    STORE
  } state_e;

  localparam logic [IDX_W:0] MAXC = (IDX_W+1)'(MAX_CHARS);

  state_e state_q, state_d;

  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W:0]        len_q, len_d;
  logic [3:0]            row_q, row_d;
  logic                  sel_q, sel_d;
  logic [1:0]            valid_q, valid_d;
  logic [1:0][IDX_W:0]   blen_q, blen_d;
  logic [1:0][10:0]      bx_q, bx_d;
  logic [IDX_W-1:0]      char_addr_q, char_addr_d;
  logic [10:0]           font_addr_q, font_addr_d;
  logic                  overrun_q, overrun_d;
  logic                  we;

  logic [7:0] bank_q [2][MAX_CHARS];

  logic [10:0]    ly11;
  logic [10:0]    ty_end;
  logic [10:0]    row_new;
  logic [IDX_W:0] len_clamp;
  logic           hit;
  logic           last;

  assign ly11      = {1'b0, line_y};
  assign ty_end    = text_y + 11'd16;
  assign row_new   = ly11 - text_y;
  assign len_clamp = (text_len > MAXC) ? MAXC : text_len;
  assign hit       = (len_clamp != '0) && (ly11 >= text_y)
                     && (ly11 < ty_end);
  assign last      = ({1'b0, idx_q} == (len_q - 1'b1));

  // State register
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a new line always restarts the fetch
  always_comb begin
    state_d = state_q;
    if (new_line) begin
      state_d = hit ? CHAR_RD : IDLE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = IDLE;
        CHAR_RD: state_d = FONT_RD;
        FONT_RD: state_d = STORE;
        STORE:   state_d = last ? IDLE : CHAR_RD;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic; addresses hold their last value outside their state
  always_comb begin
    busy        = (state_q != IDLE);
    char_addr_d = char_addr_q;
    font_addr_d = font_addr_q;
    overrun_d   = new_line && (state_q != IDLE);
    unique case (1'b1)
      (state_q == CHAR_RD): char_addr_d = idx_q;
      (state_q == FONT_RD): font_addr_d = {mem.char_data[6:0], row_q};
      default: ;
    endcase
    mem.char_addr = char_addr_d;
    mem.font_addr = font_addr_d;
    overrun       = overrun_q;
  end

  // Bank bookkeeping: swap on new_line, commit valid after the last store
  always_comb begin
    idx_d   = idx_q;
    len_d   = len_q;
    row_d   = row_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    blen_d  = blen_q;
    bx_d    = bx_q;
    we      = 1'b0;
    if (new_line) begin
      sel_d           = ~sel_q;
      valid_d[~sel_q] = 1'b0;
      blen_d[~sel_q]  = len_clamp;
      bx_d[~sel_q]    = text_x;
      idx_d           = '0;
      len_d           = len_clamp;
      row_d           = row_new[3:0];
    end else if (state_q == STORE) begin
      we = 1'b1;
      if (last) begin
        valid_d[sel_q] = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      idx_q       <= '0;
      len_q       <= '0;
      row_q       <= '0;
      sel_q       <= 1'b0;
      valid_q     <= '0;
      blen_q      <= '0;
      bx_q        <= '0;
      char_addr_q <= '0;
      font_addr_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      len_q       <= len_d;
      row_q       <= row_d;
      sel_q       <= sel_d;
      valid_q     <= valid_d;
      blen_q      <= blen_d;
      bx_q        <= bx_d;
      char_addr_q <= char_addr_d;
      font_addr_q <= font_addr_d;
      overrun_q   <= overrun_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset_n && we) begin
      bank_q[sel_q][idx_q] <= mem.font_data;
    end
  end

  // Display side: 12-bit arithmetic so strings near the right edge never wrap
  logic           dbank;
  logic [11:0]    dx;
  logic [11:0]    x12;
  logic [11:0]    span;
  logic [11:0]    col;
  logic [IDX_W-1:0] cidx;
  logic [2:0]     bsel;
  logic [7:0]     entry;
  logic           in_x;

  assign dbank = ~sel_q;
  assign dx    = {2'b00, DrawX};
  assign x12   = {1'b0, bx_q[dbank]};
  assign span  = {{(12-IDX_W-4){1'b0}}, blen_q[dbank], 3'b000};
  assign col   = dx - x12;
  assign cidx  = col[IDX_W+2:3];
  assign bsel  = 3'd7 - col[2:0];
  assign entry = bank_q[dbank][cidx];
  assign in_x  = (dx >= x12) && (dx < (x12 + span));

  always_comb begin
    pixel_on = 1'b0;
    if (valid_q[dbank] && in_x) begin
      pixel_on = entry[bsel];
    end
  end

  logic unused_sig;
  assign unused_sig = ^{DrawY, mem.char_data[7], col[11:IDX_W+3]};

endmodule

// File: tb/tb_text_line_scheduler.sv
// Randomised scoreboard bench for text_line_scheduler against a
// line-level reference model of fetch timing and displayed pixels.
module tb_text_line_scheduler;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic        new_line = 1'b0;
  logic [9:0]  line_y = '0;
  logic [10:0] text_x = '0;
  logic [10:0] text_y = '0;
  logic [4:0]  text_len = '0;
  logic        pixel_on;
  logic        busy;
  logic        overrun;

  text_line_scheduler_if #(.IDX_W(4)) mem ();

  text_line_scheduler #(.MAX_CHARS(16), .IDX_W(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .new_line(new_line), .line_y(line_y), .text_x(text_x),
    .text_y(text_y), .text_len(text_len), .mem(mem),
    .pixel_on(pixel_on), .busy(busy), .overrun(overrun)
  );

  always #5 Clk = ~Clk;

  bit [7:0] ram [16];
  bit [7:0] font [2048];

  always @(posedge Clk) begin
    mem.char_data <= ram[mem.char_addr];
    mem.font_data <= font[mem.font_addr];
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input bit ok, input string name,
                     input longint act, input longint req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  typedef struct {
    bit           ovr;
    int           busy;
    int           nca;
    int           nfa;
    bit [15:0][3:0]  ca;
    bit [15:0][10:0] fa;
    bit [1023:0]  pix;
  } exp_t;

  exp_t sb[$];

  // Reference model state: what the display bank should hold next line
  bit       prev_valid = 0;
  bit       prev_cut = 0;
  int       prev_x = 0;
  int       prev_len = 0;
  bit [7:0] prev_gl [16];

  function automatic bit [1023:0] exp_line();
    bit [1023:0] v;
    bit [7:0] g;
    int rel;
    v = '0;
    for (int x = 0; x < 1024; x++) begin
      rel = x - prev_x;
      if (prev_valid && rel >= 0 && rel < 8 * prev_len) begin
        g = prev_gl[rel / 8];
        v[x] = g[7 - (rel % 8)];
      end
    end
    return v;
  endfunction

  task automatic do_line(input int ly, input int tx, input int ty,
                         input int tl, input int g,
                         input bit sweep, input bit rst_end);
    exp_t e;
    int len, row, b;
    bit hit;
    bit [7:0] ch;
    len = (tl > 16) ? 16 : tl;
    hit = (len != 0) && (ly >= ty) && (ly < ty + 16);
    row = (ly - ty) & 15;
    b = hit ? ((3 * len < g) ? 3 * len : g) : 0;
    e.ovr = prev_cut;
    e.busy = b;
    e.nca = (b + 2) / 3;
    e.nfa = (b + 1) / 3;
    for (int i = 0; i < 16; i++) begin
      ch = ram[i];
      e.ca[i] = 4'(i);
      e.fa[i] = 11'((ch & 8'h7F) * 16 + row);
    end
    e.pix = exp_line();
    sb.push_back(e);

    line_y = 10'(ly);
    text_x = 11'(tx);
    text_y = 11'(ty);
    text_len = 5'(tl);
    new_line = 1'b1;
    DrawX = 10'($urandom_range(0, 1023));
    @(posedge Clk);
    #1;
    new_line = 1'b0;
    for (int c = 1; c < g; c++) begin
      if (sweep) DrawX = 10'((c - 1 < 1024) ? c - 1 : 1023);
      else DrawX = 10'($urandom_range(0, 1023));
      if (c == 5) begin
        line_y = 10'($urandom);
        text_x = 11'($urandom);
        text_y = 11'($urandom);
        text_len = 5'($urandom);
      end
      @(posedge Clk);
      #1;
    end
    DrawX = 10'($urandom_range(0, 1023));

    if (rst_end) begin
      prev_valid = 0;
      prev_cut = 0;
    end else begin
      prev_cut = hit && (g <= 3 * len);
      prev_valid = hit && (g > 3 * len);
      prev_x = tx;
      prev_len = len;
      for (int i = 0; i < 16; i++) begin
        ch = ram[i];
        prev_gl[i] = font[(ch & 8'h7F) * 16 + row];
      end
    end
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    @(posedge Clk);
    #1;
    chk(busy == 1'b0, "busy_after_reset", busy, 0);
    chk(pixel_on == 1'b0, "pixel_after_reset", pixel_on, 0);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
  endtask

  // Monitor: gathers one scanline interval, then scores it
  bit          m_active = 0;
  int          m_cyc, m_nb, m_nca, m_nfa, m_novr, m_ovr_at;
  bit [15:0][3:0]  m_ca;
  bit [15:0][10:0] m_fa;
  bit [1023:0] m_act, m_seen;

  task automatic finalize();
    exp_t e;
    bit ok;
    int bad;
    bit [1023:0] diff;
    if (sb.size() == 0) begin
      chk(1'b0, "scoreboard_underflow", 0, 1);
      return;
    end
    e = sb.pop_front();
    chk(m_nb == e.busy, "busy_cycles", m_nb, e.busy);
    ok = (m_novr == int'(e.ovr)) && (!e.ovr || m_ovr_at == 1);
    chk(ok, "overrun_pulse", m_novr, e.ovr);
    ok = (m_nca == e.nca);
    bad = -1;
    for (int k = 0; k < m_nca && k < 16; k++)
      if (m_ca[k] != e.ca[k] && bad < 0) bad = k;
    chk(ok && bad < 0, "char_addr_seq",
        (bad < 0) ? m_nca : m_ca[bad], (bad < 0) ? e.nca : e.ca[bad]);
    ok = (m_nfa == e.nfa);
    bad = -1;
    for (int k = 0; k < m_nfa && k < 16; k++)
      if (m_fa[k] != e.fa[k] && bad < 0) bad = k;
    chk(ok && bad < 0, "font_addr_seq",
        (bad < 0) ? m_nfa : m_fa[bad], (bad < 0) ? e.nfa : e.fa[bad]);
    diff = (m_act ^ e.pix) & m_seen;
    bad = -1;
    for (int x = 0; x < 1024; x++)
      if (diff[x] && bad < 0) bad = x;
    if (bad < 0) chk(1'b1, "pixel_line", 0, 0);
    else begin
      checks++;
      failures++;
      $display("FAIL pixel_line DrawX=%0d actual=%0d required=%0d",
               bad, m_act[bad], e.pix[bad]);
    end
  endtask

  always @(negedge Clk) begin
    if (m_active) begin
      m_cyc++;
      if (busy) begin
        m_nb++;
        if (m_nb % 3 == 1 && m_nca < 16) begin
          m_ca[m_nca] = mem.char_addr;
          m_nca++;
        end else if (m_nb % 3 == 2 && m_nfa < 16) begin
          m_fa[m_nfa] = mem.font_addr;
          m_nfa++;
        end
      end
      if (overrun) begin
        m_novr++;
        if (m_novr == 1) m_ovr_at = m_cyc;
      end
      m_act[DrawX] = pixel_on;
      m_seen[DrawX] = 1'b1;
    end
    if (!Reset_n || new_line) begin
      if (m_active) finalize();
      m_active = Reset_n;
      m_cyc = 0; m_nb = 0; m_nca = 0; m_nfa = 0;
      m_novr = 0; m_ovr_at = 0;
      m_act = '0; m_seen = '0;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int ty, ly, tl, tx, g;
    for (int i = 0; i < 2048; i++) font[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) ram[i] = 8'($urandom);
    ram[0] = 8'h41;
    font[11'h412] = 8'h3C;

    repeat (2) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    chk(pixel_on == 1'b0, "reset_pixel_on", pixel_on, 0);
    chk(busy == 1'b0, "reset_busy", busy, 0);
    chk(overrun == 1'b0, "reset_overrun", overrun, 0);
    chk(mem.char_addr == 4'd0, "reset_char_addr", mem.char_addr, 0);
    chk(mem.font_addr == 11'd0, "reset_font_addr", mem.font_addr, 0);

    do_line(52, 100, 50, 1, 1030, 1, 0);
    do_line(53, 100, 50, 1, 1030, 1, 0);
    do_line(66, 100, 50, 1, 1030, 1, 0);
    do_line(49, 100, 50, 1, 1030, 1, 0);
    for (int i = 0; i < 16; i++) ram[i] = 8'(8'h30 + i);
    do_line(50, 100, 50, 16, 1030, 1, 0);
    do_line(51, 100, 50, 20, 1030, 1, 0);
    do_line(52, 100, 50, 16, 10, 0, 0);
    do_line(53, 100, 50, 16, 1030, 1, 0);
    do_line(54, 100, 50, 16, 1030, 1, 0);
    do_line(55, 100, 50, 16, 2, 0, 1);
    do_reset();
    do_line(56, 100, 50, 16, 1030, 1, 0);
    for (int i = 0; i < 16; i++) ram[i] = 8'h7F;
    font[11'h7F7] = 8'hFF;
    do_line(57, 1020, 50, 16, 1030, 1, 0);
    do_line(58, 1020, 50, 16, 1030, 1, 0);

    for (int n = 0; n < 14; n++) begin
      if (!prev_cut)
        for (int i = 0; i < 16; i++) ram[i] = 8'($urandom);
      ty = $urandom_range(0, 900);
      ly = ty + int'($urandom_range(0, 19)) - 2;
      if (ly < 0) ly = 0;
      tl = $urandom_range(0, 31);
      tx = $urandom_range(0, 1100);
      g = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 60)) : 1030;
      do_line(ly, tx, ty, tl, g, g == 1030, 0);
    end
    do_line(300, 10, 295, 16, 1030, 1, 1);
    do_reset();
    repeat (3) @(posedge Clk);
    #1;
    chk(sb.size() == 0, "scoreboard_drain", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
